cdown60_timer: RTL
==================

// Module: cdown60_timer
// PURPOSE
//  MM:SS countdown timer built from two cascaded BCD mod-60 down-counters (seconds, minutes).
//  Counts down from a loaded preset, one step per CEN tick; raises ALARM at 00:00.
//  Counterpart to the up-counting mod-60 stopwatch; it drives the same 7-seg display path
//  and consumes the same 1 Hz CEN tick from the prescaler.
// PARAMETERS
//  ALARM_TICKS  5  number of CEN ticks ALARM stays high after reaching 00:00 (>=1)
// PORTS
//  clk         in   1  system clock, all state on posedge
//  n_rst       in   1  asynchronous active-low reset
//  CEN         in   1  count enable tick, 1 clk wide, nominally 1 Hz
//  CLR         in   1  synchronous clear: digits 00:00, state IDLE
//  LOAD        in   1  load preset digits (IDLE/PAUSE only)
//  START_STOP  in   1  single-cycle pulse: start / pause / resume / ack alarm
//  pre_mt      in   3  preset minutes tens (0-5)
//  pre_mo      in   4  preset minutes ones (0-9)
//  pre_st      in   3  preset seconds tens (0-5)
//  pre_so      in   4  preset seconds ones (0-9)
//  min_tens    out  3  current minutes tens digit
//  min_ones    out  4  current minutes ones digit
//  sec_tens    out  3  current seconds tens digit
//  sec_ones    out  4  current seconds ones digit
//  BO          out  1  seconds->minutes borrow, combinational
//  RUNNING     out  1  high in RUN state
//  ALARM       out  1  high in ALARM state
// BEHAVIOUR
//  Reset (n_rst=0, async): all digits 0, state IDLE, RUNNING=0, ALARM=0, alarm tick cnt 0, BO=0.
//  Priority per edge: CLR > LOAD > START_STOP > CEN.
//  FSM states: IDLE, RUN, PAUSE, ALARM.
//   IDLE : START_STOP & value!=00:00 -> RUN; with value==00:00 -> stays IDLE.
//   RUN  : START_STOP -> PAUSE, no decrement that cycle even if CEN=1.
//          CEN & value==00:01 -> value 00:00, -> ALARM on the same edge.
//          CEN otherwise -> decrement by 1 s.
//   PAUSE: CEN ignored; START_STOP -> RUN (IDLE if value==00:00).
//   ALARM: counts CEN ticks; after ALARM_TICKS ticks -> IDLE; START_STOP -> IDLE at once.
//   CLR in any state -> IDLE, digits 00:00.
//  First decrement happens on the first CEN strictly after the START_STOP edge.
//  LOAD honoured in IDLE/PAUSE only; ignored in RUN/ALARM. State unchanged by LOAD.
//   Out-of-range presets are clamped: ones >9 -> 9, tens >5 -> 5.
//  Decrement (BCD): sec_ones 0 -> 9 with borrow to sec_tens; sec 00 -> 59 with borrow to min;
//   min_ones 0 -> 9 with borrow to min_tens. Minutes never underflow: 00:00 exits RUN.
//  BO = (state==RUN) & CEN & !START_STOP & !CLR & (sec==00); only high while min!=00.
//  RUNNING = (state==RUN); ALARM = (state==ALARM). Both are registered state decodes.
//  Digits hold in IDLE, PAUSE and ALARM unless CLR or LOAD applies.
// TESTING
//  1 LOAD 01:00, START_STOP, 1 CEN -> 00:59; BO=1 in the CEN cycle only; RUNNING=1.
//  2 LOAD 00:02, START, 2 CEN -> 00:00, ALARM=1, RUNNING=0; 5 more CEN -> ALARM=0, IDLE.
//  3 RUN at 00:10, START_STOP+CEN same cycle -> PAUSE, 00:10 held over 3 CEN;
//    START_STOP -> RUN, next CEN -> 00:09.
//  4 LOAD pre 0,12,7,3 in IDLE -> 09:53; LOAD during RUN -> value unchanged.
//  5 Drop n_rst mid-RUN between clk edges -> all outputs 0 immediately, IDLE after release.
//  6 START_STOP at 00:00 -> stays IDLE; ALARM + START_STOP -> IDLE next edge.

Source files
------------

// File: rtl/cdown60_timer.sv
// ---------------------------------------------------------------------------
// cdown60_timer
//   MM:SS countdown timer made of two cascaded BCD mod-60 down-counters
//   (seconds feeding a borrow into minutes). A preset is loaded, START_STOP
//   starts/pauses/resumes, and every CEN tick in RUN takes one second off.
//   Reaching 00:00 enters ALARM, which lasts ALARM_TICKS CEN ticks or until
//   START_STOP acknowledges it.
//
// Ports
//   clk          in   system clock, all state on posedge
//   n_rst        in   asynchronous active-low reset
//   CEN          in   count enable tick (one clk wide)
//   CLR          in   synchronous clear to 00:00 / IDLE (highest priority)
//   LOAD         in   load clamped preset digits (IDLE / PAUSE only)
//   START_STOP   in   start / pause / resume / alarm acknowledge pulse
//   pre_mt/mo/st/so   in   preset digits (minutes tens/ones, seconds tens/ones)
//   min_tens/min_ones/sec_tens/sec_ones   out   current digits (registered)
//   BO           out  seconds->minutes borrow, combinational
//   RUNNING      out  high in RUN
//   ALARM        out  high in ALARM
//   state_dbg    out  current FSM state, for checkers and debug
//
// Handshake: none of the inputs are valid/ready channels; every control
//   input is sampled once per clk edge and acts for exactly that edge, with
//   priority CLR > LOAD > START_STOP > CEN. A control that is ignored in the
//   current state (LOAD in RUN/ALARM) does not mask lower-priority inputs.
// ---------------------------------------------------------------------------
module cdown60_timer #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       CEN,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic       START_STOP,
  input  logic [2:0] pre_mt,
  input  logic [3:0] pre_mo,
  input  logic [2:0] pre_st,
  input  logic [3:0] pre_so,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       BO,
  output logic       RUNNING,
  output logic       ALARM,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam int CW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS);
  localparam logic [CW-1:0] LAST_TICK = CW'(ALARM_TICKS - 1);

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [2:0]    mt_nx, st_nx;
  logic [3:0]    mo_nx, so_nx;

  logic sec_zero, min_zero, val_zero, val_one, load_ok;

  assign sec_zero = (sec_tens == 3'd0) && (sec_ones == 4'd0);
  assign min_zero = (min_tens == 3'd0) && (min_ones == 4'd0);
  assign val_zero = sec_zero && min_zero;
  assign val_one  = min_zero && (sec_tens == 3'd0) && (sec_ones == 4'd1);
  assign load_ok  = (state_q == S_IDLE) || (state_q == S_PAUSE);

  // Borrow out of the seconds counter: a counting tick while seconds read 00.
  // In RUN the value is never 00:00, so minutes are non-zero whenever BO is high.
  assign BO = (state_q == S_RUN) && CEN && !START_STOP && !CLR && sec_zero;

  assign RUNNING   = (state_q == S_RUN);
  assign ALARM     = (state_q == S_ALARM);
  assign state_dbg = state_q;

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    mt_nx    = min_tens;
    mo_nx    = min_ones;
    st_nx    = sec_tens;
    so_nx    = sec_ones;

    if (CLR) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      mt_nx    = 3'd0;
      mo_nx    = 4'd0;
      st_nx    = 3'd0;
      so_nx    = 4'd0;
    end else if (LOAD && load_ok) begin
      // Out-of-range BCD presets saturate to the largest legal digit.
      mt_nx = (pre_mt > 3'd5) ? 3'd5 : pre_mt;
      mo_nx = (pre_mo > 4'd9) ? 4'd9 : pre_mo;
      st_nx = (pre_st > 3'd5) ? 3'd5 : pre_st;
      so_nx = (pre_so > 4'd9) ? 4'd9 : pre_so;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START_STOP && !val_zero) state_nx = S_RUN;
        end
        S_RUN: begin
          if (START_STOP) begin
            state_nx = S_PAUSE;
          end else if (CEN && val_one) begin
            so_nx    = 4'd0;
            state_nx = S_ALARM;
            cnt_nx   = '0;
          end else if (CEN && !val_zero) begin
            if (sec_ones != 4'd0) begin
              so_nx = sec_ones - 4'd1;
            end else begin
              so_nx = 4'd9;
              if (sec_tens != 3'd0) begin
                st_nx = sec_tens - 3'd1;
              end else begin
                // seconds wrap 00 -> 59 and borrow one minute
                st_nx = 3'd5;
                if (min_ones != 4'd0) begin
                  mo_nx = min_ones - 4'd1;
                end else begin
                  mo_nx = 4'd9;
                  mt_nx = min_tens - 3'd1;
                end
              end
            end
          end
        end
        S_PAUSE: begin
          if (START_STOP) state_nx = val_zero ? S_IDLE : S_RUN;
        end
        S_ALARM: begin
          if (START_STOP) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (CEN) begin
            if (cnt_q == LAST_TICK) begin
              state_nx = S_IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_q + 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      min_tens <= 3'd0;
      min_ones <= 4'd0;
      sec_tens <= 3'd0;
      sec_ones <= 4'd0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      min_tens <= mt_nx;
      min_ones <= mo_nx;
      sec_tens <= st_nx;
      sec_ones <= so_nx;
    end
  end

endmodule
